// File: rtl/vsync_module.sv
// rtl/vsync_module.sv - vertical raster timing: line counting through sync/back/active/front regions
// Optional: define VSYNC_ACTIVE_LOW_EN to drive vsync active-low.
module vsync_module #(
  parameter int CW = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [CW-1:0] SynchPulse,
  input  logic [CW-1:0] BackPorch,
  input  logic [CW-1:0] ActiveVideo,
  input  logic [CW-1:0] FrontPorch,
  input  logic          LineEnd,
  output logic          vsync,
  output logic          FrameEnd,
  output logic [CW-1:0] yposition
);

`ifdef VSYNC_ACTIVE_LOW_EN
  localparam logic VS_ON = 1'b0;
`else
  localparam logic VS_ON = 1'b1;
`endif

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    BACK   = 2'd1,
    ACTIVE = 2'd2,
    FRONT  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] rcount, rcount_n;
  logic          LineEnd_d;
  logic          line_event;
  logic [CW-1:0] last;
  logic          wrap;

  // Last rcount value of a region; a zero length still yields one line.
  function automatic logic [CW-1:0] last_line(input logic [CW-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  assign line_event = LineEnd & ~LineEnd_d;

  always_comb begin
    last = '0;
    unique case (state)
      SYNC:   last = last_line(SynchPulse);
      BACK:   last = last_line(BackPorch);
      ACTIVE: last = last_line(ActiveVideo);
      FRONT:  last = last_line(FrontPorch);
      default: last = '0;
    endcase
  end

  always_comb begin
    state_n  = state;
    rcount_n = rcount;
    wrap     = 1'b0;
    if (line_event) begin
      if (rcount >= last) begin
        rcount_n = '0;
        unique case (state)
          SYNC:   state_n = BACK;
          BACK:   state_n = ACTIVE;
          ACTIVE: state_n = FRONT;
          FRONT: begin
            state_n = SYNC;
            wrap    = 1'b1;
          end
          default: state_n = SYNC;
        endcase
      end else begin
        rcount_n = rcount + 1'b1;
      end
    end
  end

  // Edge detector keeps tracking LineEnd through reset so a strobe held across release is not counted.
  always_ff @(posedge clock) begin
    LineEnd_d <= LineEnd;
    if (reset) begin
      state     <= SYNC;
      rcount    <= '0;
      vsync     <= VS_ON;
      FrameEnd  <= 1'b0;
      yposition <= '0;
    end else begin
      state     <= state_n;
      rcount    <= rcount_n;
      vsync     <= (state_n == SYNC) ? VS_ON : ~VS_ON;
      FrameEnd  <= wrap;
      yposition <= (state_n == ACTIVE) ? rcount_n : '0;
    end
  end

endmodule

// File: tb/tb_vsync_module.sv
// tb/tb_vsync_module.sv - directed self-checking bench for vsync_module
module tb_vsync_module;

`ifdef VSYNC_ACTIVE_LOW_EN
  localparam logic VS_ON = 1'b0;
`else
  localparam logic VS_ON = 1'b1;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] SynchPulse, BackPorch, ActiveVideo, FrontPorch;
  logic       LineEnd;
  logic       vsync, FrameEnd;
  logic [9:0] yposition;

  int checks = 0;
  int failures = 0;

  vsync_module #(.CW(10)) dut (
    .clock(clock),
    .reset(reset),
    .SynchPulse(SynchPulse),
    .BackPorch(BackPorch),
    .ActiveVideo(ActiveVideo),
    .FrontPorch(FrontPorch),
    .LineEnd(LineEnd),
    .vsync(vsync),
    .FrameEnd(FrameEnd),
    .yposition(yposition)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic ev, input logic ef, input logic [9:0] ey);
    chk({tag, ".vsync"}, {15'd0, vsync}, {15'd0, ev});
    chk({tag, ".frameend"}, {15'd0, FrameEnd}, {15'd0, ef});
    chk({tag, ".ypos"}, {6'd0, yposition}, {6'd0, ey});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One-clock LineEnd pulse; returns one clock after the rise, when outputs show the event.
  task automatic pulse();
    LineEnd = 1'b1;
    tick(1);
    LineEnd = 1'b0;
  endtask

  // 12-line frame for SP=2 BP=3 AV=5 FP=2, LineEnd high for hi clocks then low for gap clocks.
  task automatic run_frame(input string nm, input int hi, input int gap);
    logic          ev;
    logic          ef;
    logic [9:0]    ey;
    for (int k = 1; k <= 12; k++) begin
      ev = (k == 1 || k == 12) ? VS_ON : ~VS_ON;
      ef = (k == 12);
      ey = (k >= 5 && k <= 9) ? 10'(k - 5) : 10'd0;
      LineEnd = 1'b1;
      tick(1);
      outs($sformatf("%s.ev%0d", nm, k), ev, ef, ey);
      if (hi > 1) tick(hi - 1);
      LineEnd = 1'b0;
      tick(gap);
      outs($sformatf("%s.hold%0d", nm, k), ev, 1'b0, ey);
    end
  endtask

  initial begin
    reset = 1'b1;
    LineEnd = 1'b0;
    SynchPulse = 10'd2;
    BackPorch = 10'd3;
    ActiveVideo = 10'd5;
    FrontPorch = 10'd2;

    // Reset held 6 clocks
    for (int i = 0; i < 6; i++) begin
      tick(1);
      outs($sformatf("rst%0d", i), VS_ON, 1'b0, 10'd0);
    end
    reset = 1'b0;
    tick(3);
    outs("postrst", VS_ON, 1'b0, 10'd0);

    run_frame("f1", 1, 7);
    run_frame("f2", 1, 7);
    run_frame("long", 5, 3);

    // Reset coinciding with a LineEnd rise while yposition=3
    for (int k = 1; k <= 8; k++) begin
      pulse();
      tick(3);
    end
    outs("pre_midrst", ~VS_ON, 1'b0, 10'd3);
    reset = 1'b1;
    LineEnd = 1'b1;
    tick(1);
    outs("midrst", VS_ON, 1'b0, 10'd0);
    reset = 1'b0;
    tick(2);
    outs("midrst_hold", VS_ON, 1'b0, 10'd0);
    LineEnd = 1'b0;
    tick(2);
    run_frame("after_rst", 1, 4);

    // Zero back porch and active length shrunk mid-region
    BackPorch = 10'd0;
    pulse(); outs("z.ev1", VS_ON, 1'b0, 10'd0);
    tick(2);
    pulse(); outs("z.ev2", ~VS_ON, 1'b0, 10'd0);
    tick(2);
    pulse(); outs("z.ev3", ~VS_ON, 1'b0, 10'd0);
    tick(2);
    pulse(); outs("z.ev4", ~VS_ON, 1'b0, 10'd1);
    tick(2);
    pulse(); outs("z.ev5", ~VS_ON, 1'b0, 10'd2);
    tick(2);
    pulse(); outs("z.ev6", ~VS_ON, 1'b0, 10'd3);
    ActiveVideo = 10'd2;
    tick(2);
    outs("z.shrink_hold", ~VS_ON, 1'b0, 10'd3);
    pulse(); outs("z.ev7", ~VS_ON, 1'b0, 10'd0);
    tick(2);
    pulse(); outs("z.ev8", ~VS_ON, 1'b0, 10'd0);
    tick(2);
    pulse(); outs("z.ev9", VS_ON, 1'b1, 10'd0);
    tick(1);
    outs("z.fe_one", VS_ON, 1'b0, 10'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
